// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad entry controller: keycodes, command opcodes, FSM states.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ENTRY = 2'b01,
    ST_ISSUE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_EQU = 2'b11
  } cmd_op_e;

  localparam logic [4:0] KEY_ADD = 5'b01010;
  localparam logic [4:0] KEY_MUL = 5'b00010;
  localparam logic [4:0] KEY_SUB = 5'b00011;
  localparam logic [4:0] KEY_EQU = 5'b00100;

  function automatic logic is_cmd_key(input logic [4:0] key);
    return (key == KEY_ADD) || (key == KEY_MUL) || (key == KEY_SUB) || (key == KEY_EQU);
  endfunction

  function automatic cmd_op_e key_to_op(input logic [4:0] key);
    case (key)
      KEY_MUL: return OP_MUL;
      KEY_SUB: return OP_SUB;
      KEY_EQU: return OP_EQU;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/hex_shift_reg.sv
// Hex digit entry register: loads/shifts nibbles in from the right, saturating digit count
// and a sticky overflow flag for digits dropped while full.
module hex_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_all_i,
  input  logic             clr_entry_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-1:0] operand_o,
  output logic             ovf_o
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  logic [WIDTH-1:0] operand_q, operand_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  // clear key wins over everything; a completed command keeps ovf sticky
  always_comb begin
    operand_d = operand_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (clr_all_i) begin
      operand_d = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
    end else if (clr_entry_i) begin
      operand_d = '0;
      count_d   = '0;
    end else if (load_i) begin
      operand_d = {{(WIDTH-4){1'b0}}, digit_i};
      count_d   = CW'(1);
    end else if (shift_i) begin
      if (count_q < FULL) begin
        operand_d = {operand_q[WIDTH-5:0], digit_i};
        count_d   = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      operand_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      operand_q <= operand_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign operand_o = operand_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/keypad_entry_fsm.sv
// Keypad operand entry: collects hex digits and hands operator/equals commands to a
// downstream ALU over a valid/ready handshake, ignoring keys while a command is pending.
module keypad_entry_fsm
  import keypad_pkg::*;
#(
  parameter int         WIDTH  = 16,
  parameter logic [4:0] CLRKEY = 5'b00001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             newkey,
  input  logic [4:0]       keycode,
  output logic [WIDTH-1:0] operand,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_ready,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state
);

  state_e           state_q;
  logic             cmd_valid_q;
  cmd_op_e          cmd_op_q;
  logic [WIDTH-1:0] cmd_data_q;

  logic accept_keys, key_clr, key_cmd, key_digit, cmd_accept;

  assign accept_keys = (state_q == ST_IDLE) || (state_q == ST_ENTRY);
  assign key_clr     = accept_keys && newkey && (keycode == CLRKEY);
  assign key_cmd     = accept_keys && newkey && !key_clr && is_cmd_key(keycode);
  assign key_digit   = accept_keys && newkey && !key_clr && keycode[4];
  assign cmd_accept  = (state_q == ST_ISSUE) && cmd_valid_q && cmd_ready;

  hex_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clock       (clock),
    .reset       (reset),
    .clr_all_i   (key_clr),
    .clr_entry_i (cmd_accept),
    .load_i      (key_digit && (state_q == ST_IDLE)),
    .shift_i     (key_digit && (state_q == ST_ENTRY)),
    .digit_i     (keycode[3:0]),
    .operand_o   (operand),
    .ovf_o       (ovf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_ADD;
      cmd_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          if (key_clr) begin
            state_q <= ST_IDLE;
          end else if (key_cmd) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= key_to_op(keycode);
            cmd_data_q  <= operand;
            state_q     <= ST_ISSUE;
          end else if (key_digit) begin
            state_q <= ST_ENTRY;
          end
        end
        ST_ISSUE: begin
          if (cmd_accept) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign busy      = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_data  = cmd_data_q;
  assign state     = state_q;

endmodule

// File: doc/keypad_entry_fsm.md
KEYPAD_ENTRY_FSM -- requirements
Module: keypad_entry_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; multiple of 4, range 8..32; DIGITS = WIDTH/4.
REQ-002 SHALL have parameter CLRKEY, default 5'b00001: keycode of the clear key.
REQ-003 SHALL have port clock  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high.
REQ-005 SHALL have port newkey  input  1: high for one cycle per new keypress.
REQ-006 SHALL have port keycode  input  5: bit4=1 is hex digit keycode[3:0]; 01010 add, 00010 multiply, 00011 subtract, 00100 equals.
REQ-007 SHALL have port operand  output  WIDTH: current entry register (display value).
REQ-008 SHALL have port cmd_valid  output  1: command to downstream ALU pending.
REQ-009 SHALL have port cmd_op  output  2: 00 add, 01 multiply, 10 subtract, 11 equals.
REQ-010 SHALL have port cmd_data  output  WIDTH: operand carried with the command.
REQ-011 SHALL have port cmd_ready  input  1: downstream accepts the command this cycle.
REQ-012 SHALL have port ovf  output  1: sticky; a digit was dropped because the entry was full.
REQ-013 SHALL have port busy  output  1: equals cmd_valid; keys are ignored while high.
REQ-014 SHALL have port state  output  2: current FSM state, for debug.

Function
REQ-015 SHALL implement states IDLE=00 (no digits since last clear/command), ENTRY=01 (at least one digit), ISSUE=10 (command pending); 11 unused, recovers to IDLE.
REQ-016 SHALL, on a digit in IDLE, load operand with the zero-extended digit, set digit count to 1, go to ENTRY.
REQ-017 SHALL, on a digit in ENTRY with count < DIGITS, shift operand left 4 bits, insert the digit at [3:0], and increment count.
REQ-018 SHALL, on a digit in ENTRY with count = DIGITS, leave operand unchanged and set ovf; count saturates and never wraps.
REQ-019 SHALL, on an operator or equals in IDLE or ENTRY, register cmd_data = operand and cmd_op = code, assert cmd_valid on the next cycle, and go to ISSUE (one-cycle latency).
REQ-020 SHALL hold cmd_valid, cmd_op and cmd_data stable in ISSUE until a rising edge with cmd_valid and cmd_ready both high.
REQ-021 SHALL, at that edge, clear cmd_valid, operand and count, and go to IDLE.
REQ-022 SHALL ignore every key, including clear, while in ISSUE.
REQ-023 SHALL ignore cmd_ready while cmd_valid is low.
REQ-024 SHALL, on CLRKEY in IDLE or ENTRY, clear operand, count and ovf, and go to IDLE.
REQ-025 SHALL ignore keycodes with bit4=0 that match no operator, equals or CLRKEY.
REQ-026 SHALL allow an operator in IDLE; it sends the current operand (0 after reset, clear or a completed command).

Reset
REQ-027 SHALL, while reset is high and regardless of clock, force state to IDLE and operand, cmd_valid, cmd_op, cmd_data, ovf, busy and count to 0.
REQ-028 SHALL, when reset is asserted during ISSUE, drop the pending command with no acceptance.

Structure
REQ-029 SHALL place keycode constants, the cmd_op encoding and the state encoding in shared package keypad_pkg.
REQ-030 SHALL place the digit shift register, count and ovf in sub-module hex_shift_reg (parameter WIDTH).

Verification (WIDTH=16)
REQ-031 SHALL check: reset; digits 1,2,3 -> operand 0x0123, state ENTRY, cmd_valid 0.
REQ-032 SHALL check: digits 1,2,3,4,5 -> operand 0x1234, ovf 1; then clear -> operand 0, ovf 0, state IDLE.
REQ-033 SHALL check: digits A,B; add with cmd_ready=0 for 3 cycles -> cmd_valid high from the cycle after the key, cmd_op 00, cmd_data 0x00AB, all stable; digit 7 in that window is ignored; cmd_ready=1 -> next cycle cmd_valid 0, operand 0, IDLE.
REQ-034 SHALL check: equals in IDLE after reset, cmd_ready=1 -> cmd_valid high exactly one cycle, cmd_op 11, cmd_data 0.
REQ-035 SHALL check: reset asserted mid-cycle while cmd_valid=1 -> cmd_valid 0 before the next clock edge, state IDLE.
REQ-036 SHALL check: keycode 00111 with newkey in ENTRY -> operand, state and cmd_valid unchanged.
